vector_load_unit: RTL and testbench

- Fills one vector register per command by gathering up to VMAX scalar elements from the data scratchpad (base + i*stride) into a VMAX-lane vector.
- Issues the assembled vector as a single-cycle write to the vector register file's write port (rd, wen, data).
- Sits directly upstream of the vector register file, between the instruction issue logic and the register file write side.

---
 rtl/vlu_pkg.sv | 24 ++
 rtl/vlu_addr_gen.sv | 53 +++++
 rtl/vector_load_unit.sv | 178 +++++++++++++++++
 tb/tb_vector_load_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlu_pkg.sv
// -----------------------------------------------------------------------------
// vlu_pkg
// Shared types and helpers for the vector load unit.
//   vlu_state_t    : control FSM states (IDLE, READ, DRAIN, WRITE)
//   PERF_CNT_WIDTH : width of the optional performance counters
//   clamp_vlen()   : limits a requested element count to the lane count
// -----------------------------------------------------------------------------
package vlu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } vlu_state_t;

    localparam int unsigned PERF_CNT_WIDTH = 32;

    function automatic int unsigned clamp_vlen(input int unsigned vlen,
                                               input int unsigned vmax);
        return (vlen > vmax) ? vmax : vlen;
    endfunction

endpackage

// File: rtl/vlu_addr_gen.sv
// -----------------------------------------------------------------------------
// vlu_addr_gen
// Strided scratchpad address accumulator plus element counter.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : latch base/stride/vlen, restart the count at element 0
//   step      : advance to the next element (addr += stride, count += 1)
//   base      : word address of element 0
//   stride    : two's-complement element stride (wraps modulo 2^ADDR_WIDTH)
//   vlen      : clamped element count of the current command
//   addr      : address of the element currently being issued (registered)
//   count     : index of the element currently being issued (registered)
//   last_o    : current element is the final one of the command
// -----------------------------------------------------------------------------
module vlu_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned VLEN_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [VLEN_WIDTH-1:0] vlen,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [VLEN_WIDTH-1:0] count,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] stride_q;
    logic [VLEN_WIDTH-1:0] vlen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            count    <= '0;
            stride_q <= '0;
            vlen_q   <= '0;
        end else if (load) begin
            addr     <= base;
            count    <= '0;
            stride_q <= stride;
            vlen_q   <= vlen;
        end else if (step) begin
            // Unsigned add gives the signed-stride result modulo 2^ADDR_WIDTH.
            addr  <= addr + stride_q;
            count <= count + VLEN_WIDTH'(1);
        end
    end

    assign last_o = ((count + VLEN_WIDTH'(1)) == vlen_q);

endmodule

// File: rtl/vector_load_unit.sv
// -----------------------------------------------------------------------------
// vector_load_unit
// Gathers up to VMAX strided scratchpad words into one vector and writes it to
// the vector register file as a single-cycle write.
//   clk, rst      : clock, asynchronous active-high reset
//   cmd_valid_i   : command valid; accepted when cmd_ready_o is high
//   cmd_ready_o   : unit idle and able to accept a command
//   cmd_rd_i      : destination vector register (0 suppresses the write)
//   cmd_base_i    : word address of element 0
//   cmd_stride_i  : signed element stride
//   cmd_vlen_i    : element count (values above VMAX are clamped)
//   mem_ren_o     : scratchpad read enable
//   mem_addr_o    : scratchpad read address
//   mem_rdata_i   : read data, valid one cycle after mem_ren_o
//   rf_wen_o      : register file write enable pulse
//   rf_rd_o       : register file write index (held until the next write)
//   rf_wdata_o    : assembled vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   done_o        : one-cycle pulse when a command retires
// Optional (macro VLU_PERF_CNT_EN):
//   perf_busy_o   : saturating count of non-idle cycles
//   perf_cmds_o   : saturating count of retired commands
// -----------------------------------------------------------------------------
module vector_load_unit
    import vlu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned REG_WIDTH  = 4,
    parameter int unsigned VMAX       = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned VLEN_WIDTH = $clog2(VMAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [REG_WIDTH-1:0]       cmd_rd_i,
    input  logic [ADDR_WIDTH-1:0]      cmd_base_i,
    input  logic [ADDR_WIDTH-1:0]      cmd_stride_i,
    input  logic [VLEN_WIDTH-1:0]      cmd_vlen_i,
    output logic                       mem_ren_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
    output logic                       rf_wen_o,
    output logic [REG_WIDTH-1:0]       rf_rd_o,
    output logic [DATA_WIDTH*VMAX-1:0] rf_wdata_o,
    output logic                       done_o
`ifdef VLU_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0]  perf_busy_o,
    output logic [PERF_CNT_WIDTH-1:0]  perf_cmds_o
`endif
);

    vlu_state_t                         state;
    logic [REG_WIDTH-1:0]               rd_q;
    logic [VMAX-1:0][DATA_WIDTH-1:0]    lanes;
    logic [VMAX-1:0][DATA_WIDTH-1:0]    lanes_next;
    logic                               rd_pend;   // a read was issued last cycle
    logic [VLEN_WIDTH-1:0]              cap_idx;   // lane that read returns into
    logic [VLEN_WIDTH-1:0]              vlen_clamped;
    logic [VLEN_WIDTH-1:0]              elem_idx;
    logic                               last_elem;
    logic                               accept;

    assign accept       = cmd_valid_i && cmd_ready_o;
    assign vlen_clamped = VLEN_WIDTH'(clamp_vlen(32'(cmd_vlen_i), 32'(VMAX)));

    vlu_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .VLEN_WIDTH (VLEN_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == READ),
        .base   (cmd_base_i),
        .stride (cmd_stride_i),
        .vlen   (vlen_clamped),
        .addr   (mem_addr_o),
        .count  (elem_idx),
        .last_o (last_elem)
    );

    // Lane buffer with this cycle's returning read data merged in. The DRAIN
    // cycle writes this merged view straight to rf_wdata_o so the final
    // element is included without an extra cycle.
    always_comb begin
        lanes_next = lanes;
        for (int unsigned i = 0; i < VMAX; i++) begin
            if (rd_pend && (cap_idx == VLEN_WIDTH'(i))) begin
                lanes_next[i] = mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            mem_ren_o   <= 1'b0;
            rf_wen_o    <= 1'b0;
            rf_rd_o     <= '0;
            rf_wdata_o  <= '0;
            done_o      <= 1'b0;
            rd_q        <= '0;
            lanes       <= '0;
            rd_pend     <= 1'b0;
            cap_idx     <= '0;
        end else begin
            rd_pend  <= mem_ren_o;
            cap_idx  <= elem_idx;
            lanes    <= lanes_next;
            rf_wen_o <= 1'b0;
            done_o   <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q        <= cmd_rd_i;
                        lanes       <= '0;
                        cmd_ready_o <= 1'b0;
                        if (vlen_clamped == '0) begin
                            state      <= WRITE;
                            rf_wen_o   <= (cmd_rd_i != '0);
                            rf_rd_o    <= cmd_rd_i;
                            rf_wdata_o <= '0;
                            done_o     <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_ren_o <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (last_elem) begin
                        state     <= DRAIN;
                        mem_ren_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    state      <= WRITE;
                    rf_wen_o   <= (rd_q != '0);
                    rf_rd_o    <= rd_q;
                    rf_wdata_o <= lanes_next;
                    done_o     <= 1'b1;
                end
                WRITE: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                    mem_ren_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef VLU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_o <= '0;
            perf_cmds_o <= '0;
        end else begin
            if ((state != IDLE) && (perf_busy_o != '1)) begin
                perf_busy_o <= perf_busy_o + PERF_CNT_WIDTH'(1);
            end
            if (done_o && (perf_cmds_o != '1)) begin
                perf_cmds_o <= perf_cmds_o + PERF_CNT_WIDTH'(1);
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vector_load_unit.sv
module tb_vector_load_unit;

    localparam int DW = 16;
    localparam int VM = 8;
    localparam int WW = DW * VM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [3:0]    cmd_rd_i = '0;
    logic [15:0]   cmd_base_i = '0;
    logic [15:0]   cmd_stride_i = '0;
    logic [3:0]    cmd_vlen_i = '0;
    logic          mem_ren_o;
    logic [15:0]   mem_addr_o;
    logic [15:0]   mem_rdata_i = '0;
    logic          rf_wen_o;
    logic [3:0]    rf_rd_o;
    logic [WW-1:0] rf_wdata_o;
    logic          done_o;
`ifdef VLU_PERF_CNT_EN
    logic [31:0]   perf_busy_o;
    logic [31:0]   perf_cmds_o;
`endif

    vector_load_unit #(
        .DATA_WIDTH (16),
        .REG_WIDTH  (4),
        .VMAX       (8),
        .ADDR_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_rd_i     (cmd_rd_i),
        .cmd_base_i   (cmd_base_i),
        .cmd_stride_i (cmd_stride_i),
        .cmd_vlen_i   (cmd_vlen_i),
        .mem_ren_o    (mem_ren_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .rf_wen_o     (rf_wen_o),
        .rf_rd_o      (rf_rd_o),
        .rf_wdata_o   (rf_wdata_o),
        .done_o       (done_o)
`ifdef VLU_PERF_CNT_EN
        ,
        .perf_busy_o  (perf_busy_o),
        .perf_cmds_o  (perf_cmds_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scratchpad: each word holds its own address plus a per-phase key.
    logic [15:0] key = 16'h0100;
    logic        req_v = 1'b0;
    logic [15:0] req_a = '0;

    always @(negedge clk) begin
        req_v = mem_ren_o;
        req_a = mem_addr_o;
    end

    always @(posedge clk) begin
        #1;
        mem_rdata_i = req_v ? (req_a + key) : 16'($urandom);
    end

    // Transaction-level reference model.
    bit          active = 1'b0;
    int          acc = 0, v = 0, wcyc = 0;
    logic [3:0]  m_rd = '0;
    logic [15:0] m_base = '0, m_stride = '0, m_key = '0;
    bit          held_valid = 1'b1;
    logic [3:0]  held_rd = '0;
    logic [WW-1:0] held_data = '0;
    int          acc_count = 0, last_acc_cyc = 0, last_wen_cyc = 0;
    int          wen_cnt = 0, done_cnt = 0, last_done_cyc = 0;
    logic [WW-1:0] last_wdata = '0;
    logic [15:0] addr_log[$];
    bit          exp_ren, exp_done;
    logic [WW-1:0] ed;

    always @(negedge clk) begin
        if (rst) begin
            active     = 1'b0;
            held_valid = 1'b1;
            held_rd    = '0;
            held_data  = '0;
        end else begin
            exp_done = active && (cyc == wcyc);
            exp_ren  = active && (cyc > acc) && (cyc <= acc + v);
            check("cmd_ready", cmd_ready_o, !active);
            check("mem_ren", mem_ren_o, exp_ren);
            if (exp_ren)
                check("mem_addr", mem_addr_o, 16'(m_base + 16'(cyc - acc - 1) * m_stride));
            check("done", done_o, exp_done);
            check("rf_wen", rf_wen_o, exp_done && (m_rd != 4'd0));
            if (exp_done) begin
                ed = '0;
                for (int i = 0; i < v; i++)
                    ed[i*DW +: DW] = 16'(m_base + 16'(i) * m_stride) + m_key;
                held_valid = (m_rd != 4'd0);
                held_rd    = m_rd;
                held_data  = ed;
            end
            if (held_valid) begin
                check("rf_rd", rf_rd_o, held_rd);
                check("rf_wdata", rf_wdata_o, held_data);
            end
            if (mem_ren_o) addr_log.push_back(mem_addr_o);
            if (rf_wen_o) begin
                wen_cnt++;
                last_wen_cyc = cyc;
                last_wdata   = rf_wdata_o;
            end
            if (done_o) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (exp_done) begin
                active = 1'b0;
            end else if (!active && cmd_valid_i) begin
                acc      = cyc;
                v        = (cmd_vlen_i > 4'd8) ? 8 : int'(cmd_vlen_i);
                m_rd     = cmd_rd_i;
                m_base   = cmd_base_i;
                m_stride = cmd_stride_i;
                m_key    = key;
                wcyc     = (v == 0) ? cyc + 1 : cyc + v + 2;
                active   = 1'b1;
                acc_count++;
                last_acc_cyc = cyc;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends
    // the acceptance cycle.
    task automatic send(input logic [3:0] rd, input logic [15:0] base, input logic [15:0] stride,
                        input logic [3:0] vlen, input bit keep_valid, output int acc_cyc);
        int n0;
        n0 = acc_count;
        cmd_rd_i     = rd;
        cmd_base_i   = base;
        cmd_stride_i = stride;
        cmd_vlen_i   = vlen;
        cmd_valid_i  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (acc_count != n0) break;
        end
        check("cmd_accepted", acc_count != n0, 1'b1);
        #1;
        if (!keep_valid) cmd_valid_i = 1'b0;
        acc_cyc = last_acc_cyc;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (!active) break;
            @(posedge clk);
            #1;
        end
        check("idle_reached", active, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int a1, a2, wc, dc;
    logic [15:0] exp_addrs[$];

    initial begin
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", cmd_ready_o, 1'b1);
        check("reset_wdata", rf_wdata_o, '0);
        check("reset_mem_ren", mem_ren_o, 1'b0);
        @(posedge clk);
        #1;

        // Unit stride, full vector, pinned against literal values.
        key = 16'h0100;
        addr_log.delete();
        send(4'd3, 16'h0010, 16'h0001, 4'd8, 1'b0, a1);
        wait_idle();
        check("t1_write_cycle", last_wen_cyc - a1, 10);
        check("t1_done_cycle", last_done_cyc - a1, 10);
        check("t1_nreads", addr_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t1_addr", addr_log[i], 16'h0010 + 16'(i));
            check("t1_lane", last_wdata[i*DW +: DW], 16'h0110 + 16'(i));
        end

        // Negative stride and wrap-around.
        key = 16'($urandom);
        addr_log.delete();
        send(4'd5, 16'hFFFE, 16'hFFFF, 4'd3, 1'b0, a1);
        wait_idle();
        exp_addrs = '{16'hFFFE, 16'hFFFD, 16'hFFFC};
        check("t2_nreads", addr_log.size(), 3);
        for (int i = 0; i < 3; i++) check("t2_addr", addr_log[i], exp_addrs[i]);
        addr_log.delete();
        send(4'd6, 16'hFFFF, 16'h0002, 4'd2, 1'b0, a1);
        wait_idle();
        exp_addrs = '{16'hFFFF, 16'h0001};
        check("t2w_nreads", addr_log.size(), 2);
        for (int i = 0; i < 2; i++) check("t2w_addr", addr_log[i], exp_addrs[i]);

        // Short vector, empty vector, over-long vector.
        send(4'd7, 16'h1234, 16'h0010, 4'd2, 1'b0, a1);
        wait_idle();
        check("t3_upper_lanes_zero", last_wdata[WW-1:2*DW], '0);
        addr_log.delete();
        send(4'd8, 16'h4000, 16'h0001, 4'd0, 1'b0, a1);
        wait_idle();
        check("t3_zero_write_cycle", last_wen_cyc - a1, 1);
        check("t3_zero_nreads", addr_log.size(), 0);
        check("t3_zero_data", last_wdata, '0);
        addr_log.delete();
        send(4'd9, 16'h0300, 16'h0004, 4'd12, 1'b0, a1);
        wait_idle();
        check("t3_clamp_nreads", addr_log.size(), 8);
        check("t3_clamp_write_cycle", last_wen_cyc - a1, 10);

        // Register 0: reads and done, no write.
        addr_log.delete();
        wc = wen_cnt;
        dc = done_cnt;
        send(4'd0, 16'h0500, 16'h0001, 4'd4, 1'b0, a1);
        wait_idle();
        check("t4_nreads", addr_log.size(), 4);
        check("t4_no_wen", wen_cnt - wc, 0);
        check("t4_done", done_cnt - dc, 1);

        // Reset in the middle of a load.
        wc = wen_cnt;
        dc = done_cnt;
        send(4'd2, 16'h0200, 16'h0003, 4'd8, 1'b0, a1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_abort_mem_ren", mem_ren_o, 1'b0);
        check("t5_abort_wdata", rf_wdata_o, '0);
        check("t5_abort_done", done_o, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_ready_after", cmd_ready_o, 1'b1);
        check("t5_no_partial_write", wen_cnt - wc, 0);
        check("t5_no_done", done_cnt - dc, 0);
        send(4'd4, 16'h0600, 16'h0002, 4'd5, 1'b0, a1);
        wait_idle();
        check("t5_recovery_write", wen_cnt - wc, 1);

        // Back-to-back commands with valid held high.
        do_reset();
`ifdef VLU_PERF_CNT_EN
        check("t6_perf_busy_reset", perf_busy_o, '0);
        check("t6_perf_cmds_reset", perf_cmds_o, '0);
`endif
        send(4'd1, 16'h0040, 16'h0001, 4'd8, 1'b1, a1);
        send(4'd2, 16'h0080, 16'h0001, 4'd8, 1'b0, a2);
        wait_idle();
        check("t6_second_accept", a2 - a1, 11);
`ifdef VLU_PERF_CNT_EN
        check("t6_perf_cmds", perf_cmds_o, 32'd2);
        check("t6_perf_busy", perf_busy_o, 32'd20);
`endif

        // Randomized commands against the model.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] stride;
            bit keep;
            if ($urandom_range(0, 3) == 0) stride = 16'($urandom);
            else stride = 16'($urandom_range(0, 8)) - 16'd4;
            keep = (n != 39) && ($urandom_range(0, 3) == 0);
            send(4'($urandom), 16'($urandom), stride, 4'($urandom_range(0, 12)), keep, a1);
            if (!keep) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                key = 16'($urandom);
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
